// File: rtl/div_pkg.sv
// Shared definitions for the iterative RV32M divider: op encodings, FSM states and constants.
package div_pkg;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  localparam int unsigned DIV_STEPS = 32;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } div_state_e;

  // Two's complement negation; |INT_MIN| wraps back to INT_MIN, read as unsigned.
  function automatic logic [31:0] neg32(input logic [31:0] x);
    return 32'd0 - x;
  endfunction

endpackage

// File: rtl/sub_32.sv
// 32-bit ripple subtractor shared with the ALU; cout_o = 1 means no borrow (a_i >= b_i).
module sub_32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] diff_o,
  output logic        cout_o
);

  assign {cout_o, diff_o} = {1'b0, a_i} + {1'b0, ~b_i} + 33'd1;

endmodule

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
module div_unit
  import div_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_flush,
  output logic        o_busy,
  output logic        o_valid,
  output logic [31:0] o_result
);

  localparam logic [4:0] LastCnt = 5'(DIV_STEPS - 1);

  div_state_e  state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  logic [31:0] result_q, result_d;

  logic        start_signed;
  logic        start_special;
  logic [31:0] special_result;
  logic [31:0] trial_a;
  logic [31:0] trial_diff;
  logic        trial_cout;
  logic        qbit;
  logic [31:0] step_rem;
  logic [31:0] step_quo;
  logic [31:0] final_quo;
  logic [31:0] final_rem;

  assign start_signed  = ~i_op[0];
  assign start_special = (i_b == 32'd0) ||
                         (start_signed && (i_a == INT_MIN) && (i_b == 32'hFFFF_FFFF));

  always_comb begin
    special_result = 32'd0;
    if (i_b == 32'd0) begin
      special_result = i_op[1] ? i_a : 32'hFFFF_FFFF;
    end else begin
      special_result = i_op[1] ? 32'd0 : INT_MIN;
    end
  end

  assign trial_a = {rem_q[30:0], dvd_q[31]};

  sub_32 u_sub (
    .a_i    (trial_a),
    .b_i    (dvs_q),
    .diff_o (trial_diff),
    .cout_o (trial_cout)
  );

  // A set rem[31] means the shifted partial remainder exceeds 2^32, so the trial always succeeds.
  assign qbit      = rem_q[31] | trial_cout;
  assign step_rem  = qbit ? trial_diff : trial_a;
  assign step_quo  = {quo_q[30:0], qbit};
  assign final_quo = neg_quo_q ? neg32(step_quo) : step_quo;
  assign final_rem = neg_rem_q ? neg32(step_rem) : step_rem;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      op_q      <= 2'b00;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dvd_q     <= 32'd0;
      dvs_q     <= 32'd0;
      rem_q     <= 32'd0;
      quo_q     <= 32'd0;
      cnt_q     <= 5'd0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      result_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      result_q  <= result_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (i_start) state_d = start_special ? StDone : StCalc;
      StCalc: if (cnt_q == LastCnt) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (i_flush) state_d = StIdle;
  end

  always_comb begin
    op_d      = op_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    if (state_q == StIdle && state_d != StIdle) begin
      op_d      = i_op;
      neg_quo_d = start_signed && (i_a[31] ^ i_b[31]);
      neg_rem_d = start_signed && i_a[31];
      dvd_d     = (start_signed && i_a[31]) ? neg32(i_a) : i_a;
      dvs_d     = (start_signed && i_b[31]) ? neg32(i_b) : i_b;
      rem_d     = 32'd0;
      quo_d     = 32'd0;
      cnt_d     = 5'd0;
      if (state_d == StDone) result_d = special_result;
    end else if (state_q == StCalc) begin
      rem_d = step_rem;
      quo_d = step_quo;
      dvd_d = {dvd_q[30:0], 1'b0};
      cnt_d = cnt_q + 5'd1;
      if (state_d == StDone) result_d = op_q[1] ? final_rem : final_quo;
    end
  end

  always_comb begin
    busy_d  = (state_d != StIdle);
    valid_d = (state_d == StDone);
  end

  assign o_busy   = busy_q;
  assign o_valid  = valid_q;
  assign o_result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: results, latency, special cases, flush and reset.
module tb_div_unit;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [1:0]  i_op = 2'b00;
  logic [31:0] i_a = 32'd0;
  logic [31:0] i_b = 32'd0;
  logic        i_flush = 1'b0;
  logic        o_busy;
  logic        o_valid;
  logic [31:0] o_result;

  int checks = 0;
  int errors = 0;

  div_unit dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_start  (i_start),
    .i_op     (i_op),
    .i_a      (i_a),
    .i_b      (i_b),
    .i_flush  (i_flush),
    .o_busy   (o_busy),
    .o_valid  (o_valid),
    .o_result (o_result)
  );

  always #5 i_clk = ~i_clk;

  // Caller sits 1 time unit after a rising edge; returns at the first cycle with o_valid high.
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    int guard = 0;
    while (o_busy && guard < 100) begin
      @(posedge i_clk); #1;
      guard++;
    end
    i_op = op; i_a = a; i_b = b; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    lat = 1;
    while (!o_valid && lat < 100) begin
      @(posedge i_clk); #1;
      lat++;
    end
    res = o_result;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    #12;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %h want 0", o_busy); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %h want 0", o_valid); end
    checks++; if (o_result !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 0", o_result); end
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
  endtask

  task automatic test_unsigned();
    logic [31:0] r; int lat;
    launch(2'b01, 32'd100, 32'd7, r, lat);
    checks++; if (r !== 32'd14) begin errors++; $display("FAIL divu_100_7 got %h want %h", r, 32'd14); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL divu_latency got %0d want 33", lat); end
    @(posedge i_clk); #1;
    checks++; if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
      errors++; $display("FAIL valid_pulse got valid %h busy %h want 0 0", o_valid, o_busy);
    end
    launch(2'b11, 32'd100, 32'd7, r, lat);
    checks++; if (r !== 32'd2) begin errors++; $display("FAIL remu_100_7 got %h want 2", r); end
    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFE, r, lat);
    checks++; if (r !== 32'd1) begin errors++; $display("FAIL divu_big got %h want 1", r); end
    launch(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFE, r, lat);
    checks++; if (r !== 32'd1) begin errors++; $display("FAIL remu_big got %h want 1", r); end
  endtask

  task automatic test_signed();
    logic [31:0] r; int lat;
    launch(2'b00, 32'hFFFF_FFF9, 32'd2, r, lat);
    checks++; if (r !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_m7_2 got %h want fffffffd", r); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL div_latency got %0d want 33", lat); end
    launch(2'b10, 32'hFFFF_FFF9, 32'd2, r, lat);
    checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_m7_2 got %h want ffffffff", r); end
    launch(2'b00, 32'd7, 32'hFFFF_FFFE, r, lat);
    checks++; if (r !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_7_m2 got %h want fffffffd", r); end
  endtask

  task automatic test_special();
    logic [31:0] r; int lat;
    launch(2'b01, 32'd5, 32'd0, r, lat);
    checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_by0 got %h want ffffffff", r); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL by0_latency got %0d want 1", lat); end
    launch(2'b10, 32'hFFFF_FFFB, 32'd0, r, lat);
    checks++; if (r !== 32'hFFFF_FFFB) begin errors++; $display("FAIL rem_by0 got %h want fffffffb", r); end
    launch(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
    checks++; if (r !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf got %h want 80000000", r); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL ovf_latency got %0d want 1", lat); end
    launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL rem_ovf got %h want 0", r); end
    launch(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL divu_no_ovf got %h want 0", r); end
  endtask

  task automatic test_flush();
    logic [31:0] r; int lat; bit seen;
    launch(2'b11, 32'd100, 32'd7, r, lat);
    @(posedge i_clk); #1;
    i_op = 2'b01; i_a = 32'd100; i_b = 32'd7; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge i_clk); #1;
      if (o_valid) seen = 1;
    end
    i_flush = 1'b1;
    @(posedge i_clk); #1;
    i_flush = 1'b0;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %h want 0", o_busy); end
    checks++; if (o_valid !== 1'b0 || seen) begin errors++; $display("FAIL flush_valid got %h want 0", o_valid); end
    checks++; if (o_result !== 32'd2) begin errors++; $display("FAIL flush_result got %h want 2", o_result); end
    launch(2'b01, 32'd100, 32'd7, r, lat);
    checks++; if (r !== 32'd14 || lat !== 33) begin
      errors++; $display("FAIL after_flush got %h lat %0d want 0000000e lat 33", r, lat);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; int lat; bit seen;
    @(posedge i_clk); #1;
    i_op = 2'b01; i_a = 32'd100; i_b = 32'd7; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge i_clk); #1;
    end
    #2 i_rst_n = 1'b0;
    #1;
    checks++; if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_ctrl got busy %h valid %h want 0 0", o_busy, o_valid);
    end
    checks++; if (o_result !== 32'd0) begin errors++; $display("FAIL rst_mid_result got %h want 0", o_result); end
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge i_clk); #1;
      if (o_valid || o_busy) seen = 1;
    end
    checks++; if (seen) begin errors++; $display("FAIL rst_mid_spurious got 1 want 0"); end
    launch(2'b01, 32'd100, 32'd7, r, lat);
    checks++; if (r !== 32'd14 || lat !== 33) begin
      errors++; $display("FAIL after_reset got %h lat %0d want 0000000e lat 33", r, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; int lat;
    launch(2'b01, 32'd1000, 32'd10, r, lat);
    checks++; if (r !== 32'd100) begin errors++; $display("FAIL b2b_first got %h want 64", r); end
    // Start is asserted in the first IDLE cycle after DONE inside launch.
    launch(2'b11, 32'd1000, 32'd3, r, lat);
    checks++; if (r !== 32'd1 || lat !== 33) begin
      errors++; $display("FAIL b2b_second got %h lat %0d want 1 lat 33", r, lat);
    end
    @(posedge i_clk); #1;
    i_op = 2'b01; i_a = 32'd100; i_b = 32'd7; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_op = 2'b11; i_a = 32'd9; i_b = 32'd0;
    for (int i = 0; i < 4; i++) begin
      @(posedge i_clk); #1;
    end
    i_start = 1'b0;
    lat = 5;
    while (!o_valid && lat < 100) begin
      @(posedge i_clk); #1;
      lat++;
    end
    checks++; if (o_result !== 32'd14 || lat !== 33) begin
      errors++; $display("FAIL busy_start_ignored got %h lat %0d want 0000000e lat 33", o_result, lat);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
